// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

    localparam int DEF_ADDR_W         = 8;
    localparam int DEF_MAX_LEN        = 255;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LEN  = ST_LEN,
        DATA = ST_DATA,
        CSUM = ST_CSUM,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ins_write;
    logic [ADDR_W-1:0] ins_addr;
    logic [7:0]        instruction_write_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, ins_write, ins_addr, instruction_write_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ins_write, ins_addr, instruction_write_data
    );
endinterface

// File: rtl/program_loader_timeout_counter.sv
// Inter-byte watchdog: expires after CYCLES consecutive enabled cycles without a clear.
module loader_timeout_counter #(
    parameter int CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign expired = enable && !clear && (count_q == W'(CYCLES - 1));

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear || !enable || expired) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader (SYNC, LEN, payload, CSUM) that writes instruction memory
// and holds the CPU in reset until the checksum verifies. Optional LOADER_TIMEOUT_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int MAX_LEN        = DEF_MAX_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus,
    output logic             cpu_reset,
    output logic             load_done,
    output logic             load_err
);
    loader_state_t     state_q, state_d;
    logic              ready_en_q, ready_en_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              ins_write_q, ins_write_d;
    logic [ADDR_W-1:0] ins_addr_q, ins_addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        remaining_q, remaining_d;
    logic [7:0]        sum_q, sum_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;

    logic in_ready;
    logic accept;
    logic receiving;
    logic timeout_expired;

    assign receiving = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign in_ready  = ready_en_q && (receiving || state_q == IDLE);
    assign accept    = bus.in_valid && in_ready;

`ifdef LOADER_TIMEOUT_EN
    loader_timeout_counter #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .enable  (receiving),
        .expired (timeout_expired)
    );
`else
    // No watchdog: the loader waits indefinitely for the next byte.
    assign timeout_expired = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d     = state_q;
        ready_en_d  = 1'b1;
        cpu_reset_d = cpu_reset_q;
        ins_write_d = 1'b0;
        ins_addr_d  = ins_addr_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;

        case (state_q)
            IDLE: begin
                if (accept && bus.in_data == SYNC_BYTE) begin
                    state_d     = LEN;
                    cpu_reset_d = 1'b1;
                end
            end
            LEN: begin
                if (accept) begin
                    sum_d = '0;
                    if (int'(bus.in_data) > MAX_LEN) begin
                        state_d = ERR;
                    end else if (bus.in_data == 8'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d     = DATA;
                        remaining_d = bus.in_data;
                        addr_d      = '0;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    ins_write_d = 1'b1;
                    ins_addr_d  = addr_q;
                    wdata_d     = bus.in_data;
                    addr_d      = addr_q + 1'b1;
                    sum_d       = sum_q + bus.in_data;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == 8'd1) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (bus.in_data == sum_q) ? DONE : ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (timeout_expired) begin
            state_d = ERR;
        end

        // The CPU is released on the same edge that enters DONE.
        if (state_d == DONE) begin
            cpu_reset_d = 1'b0;
        end
        load_done_d = (state_d == DONE);
        load_err_d  = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_en_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            ins_write_q <= 1'b0;
            ins_addr_q  <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            sum_q       <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= ready_en_d;
            cpu_reset_q <= cpu_reset_d;
            ins_write_q <= ins_write_d;
            ins_addr_q  <= ins_addr_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.in_ready               = in_ready;
    assign bus.ins_write              = ins_write_q;
    assign bus.ins_addr               = ins_addr_q;
    assign bus.instruction_write_data = wdata_q;
    assign cpu_reset                  = cpu_reset_q;
    assign load_done                  = load_done_q;
    assign load_err                   = load_err_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed scoreboard bench for program_loader (MAX_LEN=4, TIMEOUT_CYCLES=16).
module tb_program_loader;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic cpu_reset;
    logic load_done;
    logic load_err;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    bit mon_on   = 1'b0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;

    program_loader_if #(.ADDR_W(8)) bus ();

    program_loader #(
        .ADDR_W         (8),
        .MAX_LEN        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Writes must match the scoreboard in order and appear exactly one cycle after accept.
    always @(negedge clk) begin
        if (mon_on) begin
            if (load_done) begin
                done_cnt++;
                check("cpu_reset_at_done", cpu_reset, 0);
            end
            if (load_err) begin
                err_cnt++;
                check("cpu_reset_at_err", cpu_reset, 1);
            end
            if (bus.ins_write) begin
                if (sb.size() == 0) begin
                    check("spurious_write", bus.ins_write, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_addr", bus.ins_addr, mon_e.addr);
                    check("wr_data", bus.instruction_write_data, mon_e.data);
                    check("wr_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_payload, input logic [7:0] addr);
        bit acc;
        acc = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        check("byte_accepted", acc, 1);
        if (acc && is_payload) sb.push_back('{addr, b, cyc});
        bus.in_valid = 1'b0;
    endtask

    // Walks the frame with a small parser so payload bytes and addresses come from the bench.
    task automatic stream(input int n, input logic [63:0] bytes, input bit gap);
        int         phase;
        int         rem;
        logic [7:0] addr;
        logic [63:0] tmp;
        logic [7:0] b;
        logic       prev_rst;
        phase = 0;
        rem   = 0;
        addr  = 8'd0;
        for (int i = 0; i < n; i++) begin
            tmp      = bytes >> (8 * (n - 1 - i));
            b        = tmp[7:0];
            prev_rst = cpu_reset;
            send_byte(b, phase == 2, addr);
            case (phase)
                0: begin
                    if (b == 8'hA5) begin
                        check("cpu_rst_on_sync", cpu_reset, 1);
                        phase = 1;
                    end else begin
                        check("cpu_rst_unchanged", cpu_reset, prev_rst);
                    end
                end
                1: begin
                    rem   = int'(b);
                    addr  = 8'd0;
                    phase = (rem == 0 || rem > 4) ? 3 : 2;
                end
                2: begin
                    addr++;
                    rem--;
                    if (rem == 0) phase = 3;
                end
                default: phase = 0;
            endcase
            if (i == n - 1) check("ready_low_at_end", bus.in_ready, 0);
            if (gap) idle(1);
        end
    endtask

    task automatic frame(input string tag, input int n, input logic [63:0] bytes, input bit gap,
                         input int exp_done, input int exp_err, input logic exp_cpu_rst);
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        stream(n, bytes, gap);
        idle(3);
        check({tag, "_done"}, done_cnt - d0, exp_done);
        check({tag, "_err"}, err_cnt - e0, exp_err);
        check({tag, "_cpu_reset"}, cpu_reset, exp_cpu_rst);
        check({tag, "_writes_drained"}, sb.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_ins_write"}, bus.ins_write, 0);
        check({tag, "_ins_addr"}, bus.ins_addr, 0);
        check({tag, "_wdata"}, bus.instruction_write_data, 0);
        check({tag, "_cpu_reset"}, cpu_reset, 1);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_load_err"}, load_err, 0);
    endtask

    initial begin
        int d0;
        int e0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("por");
        mon_on = 1'b1;
        reset  = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", bus.in_ready, 1);

        frame("good", 6, 64'hA5_03_11_22_33_66, 1'b0, 1, 0, 1'b0);
        frame("garbage_gap", 6, 64'h00_FF_A5_01_7E_7E, 1'b1, 1, 0, 1'b0);
        frame("bad_csum", 5, 64'hA5_02_10_20_31, 1'b0, 0, 1, 1'b1);
        frame("len_zero", 3, 64'hA5_00_00, 1'b0, 1, 0, 1'b0);
        frame("len_max", 7, 64'hA5_04_01_02_03_04_0A, 1'b0, 1, 0, 1'b0);
        frame("len_over", 2, 64'hA5_05, 1'b0, 0, 1, 1'b1);

        // Abort a 4-byte frame after its second payload byte.
        send_byte(8'hA5, 1'b0, 8'd0);
        send_byte(8'h04, 1'b0, 8'd0);
        send_byte(8'h01, 1'b1, 8'd0);
        send_byte(8'h02, 1'b1, 8'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midframe");
        reset = 1'b0;
        idle(4);
        check("midframe_writes_drained", sb.size(), 0);
        frame("reload", 5, 64'hA5_02_C3_3C_FF, 1'b0, 1, 0, 1'b0);

        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5, 1'b0, 8'd0);
        send_byte(8'h02, 1'b0, 8'd0);
        send_byte(8'hAA, 1'b1, 8'd0);
        idle(20);
`ifdef LOADER_TIMEOUT_EN
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_done", done_cnt - d0, 0);
        check("timeout_cpu_reset", cpu_reset, 1);
        check("timeout_idle_ready", bus.in_ready, 1);
`else
        check("no_timeout_err", err_cnt - e0, 0);
        check("no_timeout_ready", bus.in_ready, 1);
        send_byte(8'h55, 1'b1, 8'd1);
        send_byte(8'hFF, 1'b0, 8'd0);
        idle(3);
        check("no_timeout_done", done_cnt - d0, 1);
        check("no_timeout_cpu_reset", cpu_reset, 0);
`endif
        idle(2);
        check("final_writes_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for the CPU's instruction memory.
- Accepts a framed byte stream over a valid/ready interface and turns each payload byte into an instruction-memory write: ins_write pulse, address, data.
- Holds the CPU in reset while loading. Releases it only after the frame checksum verifies.
- Frame format: SYNC (0xA5), LEN (N), N payload bytes, CSUM (sum of payload bytes mod 256).

Parameters:
- ADDR_W, 8, instruction-memory address width; one payload byte per address.
- MAX_LEN, 255, maximum legal LEN; LEN > MAX_LEN is a frame error.
- TIMEOUT_CYCLES, 1024, inter-byte timeout (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte; transfer happens when in_valid && in_ready.
- ins_write  output  1  one-cycle write strobe to instruction memory.
- ins_addr  output  ADDR_W  write address.
- instruction_write_data  output  8  write data.
- cpu_reset  output  1  holds the CPU in reset.
- load_done  output  1  one-cycle pulse when a frame verifies.
- load_err  output  1  one-cycle pulse on a frame error.

Behaviour:
- Reset values:
  - state = IDLE.
  - cpu_reset = 1.
  - in_ready = 0 in the first cycle after reset; 1 thereafter per the state rules below.
  - ins_write = 0, ins_addr = 0, instruction_write_data = 0.
  - load_done = 0, load_err = 0.
  - Internal remaining count = 0, sum = 0.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- in_ready is 1 in IDLE, LEN, DATA and CSUM; 0 in DONE and ERR.
- IDLE:
  - Accepted byte ≠ 0xA5: discarded; state stays IDLE; cpu_reset unchanged.
  - Accepted byte = 0xA5: go to LEN; cpu_reset = 1 from the next cycle.
- LEN:
  - Accepted byte N:
    - N > MAX_LEN: go to ERR.
    - N = 0: go to CSUM.
    - Otherwise: go to DATA, with remaining = N, ins_addr base = 0, sum = 0.
- DATA:
  - Each accepted byte b produces, in the following cycle: ins_write = 1, instruction_write_data = b, ins_addr = current address.
  - After the write, the address increments. sum += b (mod 256). remaining decrements.
  - When remaining reaches 0 after an accept, go to CSUM.
  - Latency is exactly 1 cycle from accept to write strobe. Back-to-back accepts produce back-to-back strobes.
- CSUM:
  - Accepted byte equals sum: go to DONE.
  - Otherwise: go to ERR.
- DONE (1 cycle):
  - load_done = 1.
  - cpu_reset falls to 0 on the edge entering DONE.
  - Next state IDLE.
- ERR (1 cycle):
  - load_err = 1; cpu_reset stays 1.
  - Next state IDLE. Memory contents are undefined until a good frame loads.
- cpu_reset stays 0 until the next accepted SYNC byte in IDLE; a new frame always reloads from address 0.
- Address never wraps within a frame, because LEN ≤ MAX_LEN ≤ 2^ADDR_W − 1.
- reset asserted mid-frame: abort at once to reset values. No partial ins_write is issued in the cycle after reset.
- in_valid low: all state holds; no strobe is generated.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A counter runs in LEN, DATA and CSUM and clears on every accepted byte.
  - On reaching TIMEOUT_CYCLES, go to ERR (load_err pulse); cpu_reset stays 1.
- Undefined:
  - No counter; the loader waits indefinitely in any state.
  - TIMEOUT_CYCLES is ignored.

Decomposition:
- Package loader_pkg holds:
  - State enum loader_state_t (IDLE, LEN, DATA, CSUM, DONE, ERR).
  - Constant SYNC_BYTE = 8'hA5.
  - Default-width localparams.
- One natural sub-module: loader_timeout_counter.
  - Inputs: clk, reset, clear, enable. Output: expired.
  - Instantiated only under LOADER_TIMEOUT_EN.
- FSM, checksum accumulator and write-port registers stay in program_loader.

Test Plan:
- Good frame:
  - Stream A5,03,11,22,33,66, in_valid continuous.
  - Expect writes (addr 0,1,2) = 11,22,33 on consecutive cycles; load_done pulse; cpu_reset 1→0; load_err never 1.
- Bad checksum:
  - Stream A5,02,10,20,31.
  - Expect 2 writes, then load_err pulse, no load_done, cpu_reset stays 1.
- Length checks:
  - Stream A5,00,00: expect no writes, load_done pulse.
  - With MAX_LEN=4, stream A5,05: expect load_err and no writes.
- Garbage before sync plus backpressure:
  - Stream 00,FF,A5,01,7E,7E with in_valid toggling every other cycle.
  - Expect garbage ignored, one write addr 0 = 7E, load_done.
- Reset mid-frame then reload:
  - Assert reset after second payload byte of a 4-byte frame.
  - Expect all outputs at reset values next cycle and no further strobes.
  - A following good frame writes from addr 0 and completes.
- Timeout (LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stream A5,02,AA, then idle 16 cycles.
  - Expect load_err and return to IDLE.
  - Without the macro, no error and the loader is still in DATA.
